// File: rtl/seq_detect_pkg.sv
// Shared constants, FSM state type and length clamp for the serial pattern detector.
package seq_detect_pkg;

  // Reset-time defaults for the 8-bit-window build.
  localparam int unsigned DEF_PAT_W   = 8;
  localparam logic [7:0]  DEF_PAT_8B  = 8'b0001_1011;
  localparam int unsigned DEF_LEN_8B  = 5;
  localparam bit          DEF_OVL_8B  = 1'b1;

  // FILL: collecting the first len bits; ARMED: window holds at least len valid bits.
  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_ARMED = 1'b1
  } fill_st_e;

  // Lengths of 0 or 1 become 1; anything wider than the window becomes the window width.
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned pat_w);
    if (len < 2) begin
      return 1;
    end
    if (len > pat_w) begin
      return pat_w;
    end
    return len;
  endfunction

endpackage

// File: rtl/seq_detect_param_if.sv
// Serial data, configuration and result bundle of the pattern detector.
//   master: drives n/n_vld/cfg_*/cnt_clr, observes d/match_cnt/cur_len
//   slave : the detector
interface seq_detect_param_if #(
  parameter int unsigned PAT_W = 8,
  parameter int unsigned CNT_W = 8
);
  localparam int unsigned LEN_W = $clog2(PAT_W + 1);

  logic             n;
  logic             n_vld;
  logic             cfg_load;
  logic [PAT_W-1:0] cfg_pat;
  logic [LEN_W-1:0] cfg_len;
  logic             cfg_ovl;
  logic             cnt_clr;
  logic             d;
  logic [CNT_W-1:0] match_cnt;
  logic [LEN_W-1:0] cur_len;

  modport master (
    output n, n_vld, cfg_load, cfg_pat, cfg_len, cfg_ovl, cnt_clr,
    input  d, match_cnt, cur_len
  );

  modport slave (
    input  n, n_vld, cfg_load, cfg_pat, cfg_len, cfg_ovl, cnt_clr,
    output d, match_cnt, cur_len
  );

endinterface

// File: rtl/seq_detect_param_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rst : clock, synchronous active-high reset
//   inc      : add one (held at all-ones once reached)
//   clr      : clear; clr together with inc loads 1
//   cnt      : registered count
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= inc ? W'(1) : '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/seq_detect_param.sv
// Runtime-configurable serial pattern detector with Moore detect flag and match counter.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of seq_detect_param_if (serial data in, config, d/match_cnt/cur_len out)
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int unsigned      PAT_W   = 8,
  parameter int unsigned      CNT_W   = 8,
  parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(DEF_PAT_8B),
  parameter int unsigned      DEF_LEN = DEF_LEN_8B,
  parameter bit               DEF_OVL = DEF_OVL_8B
) (
  input logic              clk,
  input logic              rst,
  seq_detect_param_if.slave bus
);

  localparam int unsigned      LEN_W   = $clog2(PAT_W + 1);
  localparam logic [LEN_W-1:0] RST_LEN = LEN_W'(clamp_len(DEF_LEN, PAT_W));

  logic [PAT_W-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic             ovl_q;
  logic [PAT_W-1:0] win_q;
  logic [LEN_W-1:0] fill_q, fill_d;
  fill_st_e         st_q, st_d;
  logic             d_q, d_d;
  logic [CNT_W-1:0] cnt;

  logic [PAT_W-1:0] shifted_c;
  logic [PAT_W-1:0] mask_c;
  logic             full_c;
  logic             hit_c;

  // Window as it would look after taking in the current bit.
  assign shifted_c = {win_q[PAT_W-2:0], bus.n};

  // Low len_q bits set; computed one bit wider so len_q == PAT_W yields all ones.
  assign mask_c = PAT_W'(((PAT_W + 1)'(1) << len_q) - (PAT_W + 1)'(1));

  // Including the current bit, at least len_q bits have been collected.
  assign full_c = (st_q == ST_ARMED) || ((fill_q + LEN_W'(1)) == len_q);

  // A load in the same cycle discards the data bit, so it can never match.
  assign hit_c = bus.n_vld && !bus.cfg_load && full_c &&
                 (((shifted_c ^ pat_q) & mask_c) == '0);

  // Configuration registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q <= DEF_PAT;
      len_q <= RST_LEN;
      ovl_q <= DEF_OVL;
    end else if (bus.cfg_load) begin
      pat_q <= bus.cfg_pat;
      len_q <= LEN_W'(clamp_len(32'(bus.cfg_len), PAT_W));
      ovl_q <= bus.cfg_ovl;
    end
  end

  // Sample window.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_q <= '0;
    end else if (bus.cfg_load) begin
      win_q <= '0;
    end else if (bus.n_vld) begin
      win_q <= shifted_c;
    end
  end

  // Fill FSM and detect flag: state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= ST_FILL;
      fill_q <= '0;
      d_q    <= 1'b0;
    end else begin
      st_q   <= st_d;
      fill_q <= fill_d;
      d_q    <= d_d;
    end
  end

  // Fill FSM and detect flag: next state.
  always_comb begin
    st_d   = st_q;
    fill_d = fill_q;
    d_d    = 1'b0;
    if (bus.cfg_load) begin
      st_d   = ST_FILL;
      fill_d = '0;
    end else if (bus.n_vld) begin
      if (hit_c) begin
        d_d = 1'b1;
        if (ovl_q) begin
          st_d   = ST_ARMED;
          fill_d = len_q;
        end else begin
          // Non-overlapping: the next match must be built from fresh bits.
          st_d   = ST_FILL;
          fill_d = '0;
        end
      end else if (full_c) begin
        st_d   = ST_ARMED;
        fill_d = len_q;
      end else begin
        fill_d = fill_q + LEN_W'(1);
      end
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .inc (hit_c),
    .clr (bus.cnt_clr),
    .cnt (cnt)
  );

  assign bus.d         = d_q;
  assign bus.match_cnt = cnt;
  assign bus.cur_len   = len_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed-vector bench for seq_detect_param with a queue-based scoreboard.
module tb_seq_detect_param;

  localparam int unsigned PAT_W = 8;
  localparam int unsigned CNT_W = 2;
  localparam int unsigned LEN_W = $clog2(PAT_W + 1);

  typedef struct {
    logic d;
    int   cnt;   // -1: not checked this cycle
    int   len;   // -1: not checked this cycle
    int   step;
  } exp_t;

  logic clk;
  logic rst;
  exp_t exp_q[$];
  int   checks;
  int   errors;
  int   step;

  seq_detect_param_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus ();

  seq_detect_param #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of inputs and queue the response expected after the next rising edge.
  task automatic drive(input logic vld, input logic nb, input logic ld,
                       input logic [PAT_W-1:0] pat, input logic [LEN_W-1:0] len,
                       input logic ovl, input logic clr, input logic r,
                       input logic ed, input int ec, input int el);
    exp_t e;
    bus.n_vld    = vld;
    bus.n        = nb;
    bus.cfg_load = ld;
    bus.cfg_pat  = pat;
    bus.cfg_len  = len;
    bus.cfg_ovl  = ovl;
    bus.cnt_clr  = clr;
    rst          = r;
    e.d    = ed;
    e.cnt  = ec;
    e.len  = el;
    e.step = step;
    exp_q.push_back(e);
    step++;
    @(negedge clk);
  endtask

  task automatic bitn(input logic b, input logic ed, input int ec);
    drive(1'b1, b, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, ed, ec, -1);
  endtask

  task automatic idle(input int ec);
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, ec, -1);
  endtask

  task automatic load(input logic [PAT_W-1:0] pat, input logic [LEN_W-1:0] len,
                      input logic ovl, input logic clr, input int ec, input int el);
    drive(1'b0, 1'b0, 1'b1, pat, len, ovl, clr, 1'b0, 1'b0, ec, el);
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 5);
  endtask

  // Monitor: compare every output cycle that has a queued expectation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        if (bus.d !== e.d) begin
          errors++;
          $display("FAIL d step %0d: got %0b expected %0b", e.step, bus.d, e.d);
        end
        if (e.cnt >= 0) begin
          checks++;
          if (bus.match_cnt !== CNT_W'(e.cnt)) begin
            errors++;
            $display("FAIL match_cnt step %0d: got %0d expected %0d", e.step, bus.match_cnt, e.cnt);
          end
        end
        if (e.len >= 0) begin
          checks++;
          if (bus.cur_len !== LEN_W'(e.len)) begin
            errors++;
            $display("FAIL cur_len step %0d: got %0d expected %0d", e.step, bus.cur_len, e.len);
          end
        end
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    step   = 0;
    rst          = 1'b1;
    bus.n        = 1'b0;
    bus.n_vld    = 1'b0;
    bus.cfg_load = 1'b0;
    bus.cfg_pat  = '0;
    bus.cfg_len  = '0;
    bus.cfg_ovl  = 1'b0;
    bus.cnt_clr  = 1'b0;
    @(negedge clk);

    do_reset();
    do_reset();

    // Defaults 11011, len 5, overlapping: hits after bits 5 and 8.
    bitn(1, 0, -1); bitn(1, 0, -1); bitn(0, 0, -1); bitn(1, 0, 0);
    bitn(1, 1, 1);  bitn(0, 0, -1); bitn(1, 0, -1); bitn(1, 1, 2);

    // Non-overlapping: only the first hit of the same stream.
    load(8'h1B, 4'd5, 1'b0, 1'b0, 2, 5);
    bitn(1, 0, -1); bitn(1, 0, -1); bitn(0, 0, -1); bitn(1, 0, 2);
    bitn(1, 1, 3);  bitn(0, 0, -1); bitn(1, 0, -1); bitn(1, 0, 3);
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 0, -1);

    // Gaps in n_vld hold the partial match.
    load(8'h1B, 4'd5, 1'b1, 1'b0, 0, 5);
    bitn(1, 0, -1); bitn(1, 0, -1); bitn(0, 0, -1);
    idle(-1); idle(0); idle(-1);
    bitn(1, 0, -1); bitn(1, 1, 1);

    // Reset mid-sequence (also outranks load/clear/data) discards the partial match.
    bitn(1, 0, -1); bitn(1, 0, -1); bitn(0, 0, -1); bitn(1, 0, 1);
    drive(1'b1, 1'b1, 1'b1, 8'h03, 4'd2, 1'b0, 1'b1, 1'b1, 1'b0, 0, 5);
    bitn(1, 0, -1);
    bitn(1, 0, -1); bitn(1, 0, -1); bitn(0, 0, -1); bitn(1, 0, 0); bitn(1, 1, 1);

    // len 2, upper pattern bits ignored, saturation at 3, clear with concurrent hit.
    load(8'hF3, 4'd2, 1'b1, 1'b1, 0, 2);
    bitn(1, 0, 0); bitn(1, 1, 1); bitn(1, 1, 2); bitn(1, 1, 3);
    bitn(1, 1, 3); bitn(1, 1, 3); bitn(1, 1, 3);
    drive(1'b1, 1'b1, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b1, 1, -1);

    // cfg_len 0 clamps to 1: d follows the bit.
    load(8'h01, 4'd0, 1'b1, 1'b0, 1, 1);
    bitn(1, 1, 2); bitn(0, 0, 2); bitn(1, 1, 3);

    // cfg_len 12 clamps to 8: full-window pattern.
    load(8'hA6, 4'd12, 1'b0, 1'b1, 0, 8);
    bitn(1, 0, -1); bitn(0, 0, -1); bitn(1, 0, -1); bitn(0, 0, -1);
    bitn(0, 0, -1); bitn(1, 0, -1); bitn(1, 0, 0);  bitn(0, 1, 1);

    // Load with a valid bit in the same cycle: bit discarded, counter kept.
    drive(1'b1, 1'b1, 1'b1, 8'h01, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1);
    bitn(0, 0, 1); bitn(1, 1, 2);

    do_reset();

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 Parameter PAT_W, 8, maximum pattern length in bits (legal 2..32).
REQ-002 Parameter CNT_W, 8, match-counter width in bits (legal 1..32).
REQ-003 Parameter DEF_PAT, 8'b0001_1011, pattern loaded at reset, PAT_W bits wide.
REQ-004 Parameter DEF_LEN, 5, pattern length loaded at reset.
REQ-005 Parameter DEF_OVL, 1, overlap mode loaded at reset (1 = overlapping, 0 = non-overlapping).
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 n  input  1  serial data bit.
REQ-009 n_vld  input  1  n is sampled only when n_vld=1.
REQ-010 cfg_load  input  1  latch cfg_pat, cfg_len and cfg_ovl.
REQ-011 cfg_pat  input  PAT_W  new pattern; the oldest bit is compared against bit cfg_len-1, the newest against bit 0.
REQ-012 cfg_len  input  $clog2(PAT_W+1)  new pattern length.
REQ-013 cfg_ovl  input  1  new overlap mode.
REQ-014 cnt_clr  input  1  clear the match counter.
REQ-015 d  output  1  Moore detect flag, registered.
REQ-016 match_cnt  output  CNT_W  number of detections, saturating.
REQ-017 cur_len  output  $clog2(PAT_W+1)  active pattern length.

Function
REQ-018 Window: PAT_W-bit shift register. On n_vld, shift left and insert n at bit 0.
REQ-019 Fill state: fill counter, 0..len, saturating at len; increments on each n_vld while below len.
REQ-020 Match condition, evaluated on the edge that samples n:
  - fill (including the current bit) reaches len, and
  - the low len bits of {window, n} equal the low len bits of the pattern.
REQ-021 d is 1 for exactly the cycle after the edge on which a match was sampled, and 0 otherwise (Moore output, one-cycle latency).
REQ-022 n_vld=0: window, fill and counter hold; d is 0 in the next cycle.
REQ-023 Overlap mode 1: fill holds at len after a match, so shared suffix/prefix bits count toward the next match.
REQ-024 Overlap mode 0: fill resets to 0 on a match, so the next match needs len fresh bits.
REQ-025 Counter: match_cnt increments by 1 per match and saturates at 2^CNT_W-1; it never wraps.
REQ-026 cnt_clr sets match_cnt to 0 on the next edge.
REQ-027 cnt_clr and a match in the same cycle: match_cnt becomes 1.
REQ-028 cfg_load, on the next edge:
  - latches the pattern, length and mode;
  - clears the window and fill;
  - forces d to 0;
  - leaves match_cnt unchanged.
REQ-029 cfg_load and n_vld in the same cycle: cfg_load wins and the data bit is discarded.
REQ-030 cfg_len of 0 or 1 is stored as 1; cfg_len above PAT_W is stored as PAT_W; cur_len reflects the stored value.
REQ-031 len=1: d follows (n == pattern[0]) with one cycle of latency, every valid bit.
REQ-032 Pattern bits above len-1 are ignored in the comparison.

Reset
REQ-033 While rst=1 at a rising edge, all of the following take effect on that edge:
  - window = 0, fill = 0, d = 0, match_cnt = 0;
  - pattern = DEF_PAT, length = DEF_LEN (clamped per REQ-030), mode = DEF_OVL.
REQ-034 rst takes priority over cfg_load, cnt_clr and n_vld.
REQ-035 Reset mid-sequence discards any partial match; detection restarts from an empty window.

Structure
REQ-036 Package seq_detect_pkg holds:
  - the default constants for the PAT_W=8 build (DEF_PAT, DEF_LEN, DEF_OVL);
  - a length-clamp function.
REQ-037 Sub-module sat_counter (CNT_W parameter; inputs inc and clr; saturating output) implements match_cnt.
REQ-038 The top module holds the window, the fill state machine, the configuration registers and the d register.

Verification
REQ-039 Defaults (pattern 11011, len 5, overlap), n_vld=1, stream 1,1,0,1,1,0,1,1 -> d pulses after the 5th and 8th bits; match_cnt=2.
REQ-040 Same stream after cfg_load with cfg_ovl=0, cfg_pat=11011, cfg_len=5 -> d pulses after the 5th bit only; match_cnt increases by 1.
REQ-041 Stream 1,1,0,1,1 with n_vld=0 for 3 cycles inserted between the 3rd and 4th bits -> exactly one d pulse, one cycle after the 5th valid bit.
REQ-042 CNT_W=2, stream 1,1,1,1,1,1,1 with pattern 11, len 2, overlap -> 6 matches and match_cnt holds at 3; cnt_clr concurrent with a match -> match_cnt=1.
REQ-043 rst=1 after bits 1,1,0,1, followed by a single 1 -> no d pulse; the full sequence 1,1,0,1,1 after reset -> d pulse.
REQ-044 cfg_len=0 with pattern bit0=1, stream 1,0,1 -> d=1,0,1; cfg_len=12 with PAT_W=8 -> cur_len reads 8.
